// File: rtl/cv32e40p_obi_instr_responder_if.sv
// OBI instruction-side bus between a prefetch initiator (master) and its memory (slave).
interface cv32e40p_obi_instr_responder_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  modport master (
    output instr_req_i,
    output instr_addr_i,
    input  instr_gnt_o,
    input  instr_rvalid_o,
    input  instr_rdata_o,
    input  instr_err_o
  );

  modport slave (
    input  instr_req_i,
    input  instr_addr_i,
    output instr_gnt_o,
    output instr_rvalid_o,
    output instr_rdata_o,
    output instr_err_o
  );
endinterface

// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction memory responder: grants requests, answers in order after LATENCY cycles.
// Optional pseudo-random grant inhibit: define CV32E40P_OBI_RESP_RANDOM_STALL_EN.
module cv32e40p_obi_instr_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  cv32e40p_obi_instr_responder_if.slave        bus,
  input  logic                                 stall_i,
  input  logic                                 load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0]         load_addr_i,
  input  logic [31:0]                          load_wdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [31:0]                          gnt_cnt_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(4 * MEM_WORDS);

  logic [31:0]   r_mem [MEM_WORDS];
  logic          r_vld  [LATENCY];
  logic [31:0]   r_data [LATENCY];
  logic          r_err  [LATENCY];
  logic [OW-1:0] r_outstanding;
  logic [31:0]   r_gnt_cnt;

  logic          w_lfsr_stall;
  logic          w_gnt;
  logic          w_accept;
  logic          w_retire;
  logic          w_in_range;
  logic [32:0]   w_addr_ext;
  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_unused_offset;

`ifdef CV32E40P_OBI_RESP_RANDOM_STALL_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps 16,14,13,11 shifted toward the MSB
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_lfsr_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_lfsr_stall = 1'b0;
`endif

  // The limit check uses the registered count, so a same-cycle retire cannot reopen the grant
  assign w_gnt = bus.instr_req_i & ~stall_i & ~rst & ~w_lfsr_stall &
                 (r_outstanding < OW'(MAX_OUTSTANDING));
  assign bus.instr_gnt_o = w_gnt;

  assign w_accept = bus.instr_req_i & w_gnt;
  assign w_retire = r_vld[LATENCY-1];

  // 33-bit compare so addresses near 32'hFFFF_FFFF never wrap into range
  assign w_addr_ext = {1'b0, bus.instr_addr_i};
  assign w_in_range = (w_addr_ext >= BASE_EXT) && (w_addr_ext < LIMIT_EXT);
  assign w_offset   = bus.instr_addr_i - BASE_ADDR;
  assign w_idx      = w_offset[AW+1:2];
  assign w_unused_offset = {w_offset[31:AW+2], {(AW+2){1'b0}}} | {30'd0, w_offset[1:0]};

  always_ff @(posedge clk) begin
    if (load_we_i) begin
      r_mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Response pipeline: memory sampled at acceptance, data/err forced to zero when not valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_data[i] <= 32'h0;
        r_err[i]  <= 1'b0;
      end
    end else begin
      r_vld[0]  <= w_accept;
      r_data[0] <= (w_accept && w_in_range) ? r_mem[w_idx] : 32'h0;
      r_err[0]  <= w_accept && !w_in_range;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
        r_err[i]  <= r_err[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_gnt_cnt     <= 32'h0;
    end else begin
      if (w_accept && !w_retire) begin
        r_outstanding <= r_outstanding + OW'(1);
      end else if (!w_accept && w_retire) begin
        r_outstanding <= r_outstanding - OW'(1);
      end
      if (w_accept) begin
        r_gnt_cnt <= r_gnt_cnt + 32'd1;
      end
    end
  end

  assign bus.instr_rvalid_o = r_vld[LATENCY-1];
  assign bus.instr_rdata_o  = r_data[LATENCY-1];
  assign bus.instr_err_o    = r_err[LATENCY-1];
  assign outstanding_o      = r_outstanding;
  assign gnt_cnt_o          = r_gnt_cnt;

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Directed bench for cv32e40p_obi_instr_responder: three instances at LATENCY 1, 2 and 3.
module tb_cv32e40p_obi_instr_responder;

  logic        clk;
  logic        rstA, rstB, rstC;
  logic        stallA, stallB, stallC;
  logic        loadWeA, loadWeB, loadWeC;
  logic [9:0]  loadAddrA, loadAddrB, loadAddrC;
  logic [31:0] loadWdataA, loadWdataB, loadWdataC;
  logic [1:0]  outA, outB, outC;
  logic [31:0] gntCntA, gntCntB, gntCntC;

  int compared;
  int mismatched;

  logic [31:0] prog [4];

  cv32e40p_obi_instr_responder_if ifA();
  cv32e40p_obi_instr_responder_if ifB();
  cv32e40p_obi_instr_responder_if ifC();

  cv32e40p_obi_instr_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dutA (
    .clk(clk), .rst(rstA), .bus(ifA), .stall_i(stallA), .load_we_i(loadWeA),
    .load_addr_i(loadAddrA), .load_wdata_i(loadWdataA), .outstanding_o(outA), .gnt_cnt_o(gntCntA)
  );

  cv32e40p_obi_instr_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2), .MAX_OUTSTANDING(2)) u_dutB (
    .clk(clk), .rst(rstB), .bus(ifB), .stall_i(stallB), .load_we_i(loadWeB),
    .load_addr_i(loadAddrB), .load_wdata_i(loadWdataB), .outstanding_o(outB), .gnt_cnt_o(gntCntB)
  );

  cv32e40p_obi_instr_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2)) u_dutC (
    .clk(clk), .rst(rstC), .bus(ifC), .stall_i(stallC), .load_we_i(loadWeC),
    .load_addr_i(loadAddrC), .load_wdata_i(loadWdataC), .outstanding_o(outC), .gnt_cnt_o(gntCntC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    ifA.instr_req_i = 1'b1; ifA.instr_addr_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick;
      loadWeA = 1'b1; loadWeB = 1'b1; loadWeC = 1'b1;
      loadAddrA = (i < 4) ? 10'(i) : 10'd1023;
      loadWdataA = (i < 4) ? prog[i] : 32'hCAFEF00D;
      loadAddrB = 10'd0; loadWdataB = 32'h12345678;
      loadAddrC = 10'd1; loadWdataC = 32'h00100093;
    end
    @(negedge clk);
    compared++;
    if (ifA.instr_gnt_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_gnt: got %b want 0", ifA.instr_gnt_o); end
    compared++;
    if (ifA.instr_rvalid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rvalid: got %b want 0", ifA.instr_rvalid_o); end
    compared++;
    if (ifA.instr_rdata_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", ifA.instr_rdata_o); end
    compared++;
    if (ifA.instr_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 0", ifA.instr_err_o); end
    compared++;
    if (outA !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_outstanding: got %0d want 0", outA); end
    compared++;
    if (gntCntA !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_gnt_cnt: got %0d want 0", gntCntA); end
    tick;
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    loadWeA = 1'b0; loadWeB = 1'b0; loadWeC = 1'b0;
    ifA.instr_req_i = 1'b0;
    @(negedge clk);
    compared++;
    if (ifA.instr_rvalid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_rvalid: got %b want 0", ifA.instr_rvalid_o); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (k < 4) begin
        ifA.instr_req_i = 1'b1; ifA.instr_addr_i = 32'(4 * k);
      end else begin
        ifA.instr_req_i = 1'b0;
      end
      @(negedge clk);
      if (k < 4) begin
        compared++;
        if (ifA.instr_gnt_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_gnt[%0d]: got %b want 1", k, ifA.instr_gnt_o); end
      end
      if (k >= 1) begin
        compared++;
        if (ifA.instr_rvalid_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b want 1", k, ifA.instr_rvalid_o); end
        compared++;
        if (ifA.instr_rdata_o !== prog[k-1]) begin mismatched++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", k, ifA.instr_rdata_o, prog[k-1]); end
        compared++;
        if (ifA.instr_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_err[%0d]: got %b want 0", k, ifA.instr_err_o); end
      end
    end
    tick;
    @(negedge clk);
    compared++;
    if (ifA.instr_rvalid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_rvalid: got %b want 0", ifA.instr_rvalid_o); end
    compared++;
    if (gntCntA !== 32'd4) begin mismatched++; $display("[TB] FAIL b2b_gnt_cnt: got %0d want 4", gntCntA); end
    compared++;
    if (outA !== 2'd0) begin mismatched++; $display("[TB] FAIL b2b_outstanding: got %0d want 0", outA); end
  endtask

  task automatic test_error;
    tick;
    ifA.instr_req_i = 1'b1; ifA.instr_addr_i = 32'h0000_1000;
    @(negedge clk);
    compared++;
    if (ifA.instr_gnt_o !== 1'b1) begin mismatched++; $display("[TB] FAIL err_gnt: got %b want 1", ifA.instr_gnt_o); end
    tick;
    ifA.instr_addr_i = 32'h0000_0FFE;
    @(negedge clk);
    compared++;
    if (ifA.instr_rvalid_o !== 1'b1) begin mismatched++; $display("[TB] FAIL err_rvalid: got %b want 1", ifA.instr_rvalid_o); end
    compared++;
    if (ifA.instr_err_o !== 1'b1) begin mismatched++; $display("[TB] FAIL err_err: got %b want 1", ifA.instr_err_o); end
    compared++;
    if (ifA.instr_rdata_o !== 32'h0) begin mismatched++; $display("[TB] FAIL err_rdata: got %h want 0", ifA.instr_rdata_o); end
    tick;
    ifA.instr_addr_i = 32'hFFFF_FFFC;
    @(negedge clk);
    compared++;
    if (ifA.instr_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL top_word_err: got %b want 0", ifA.instr_err_o); end
    compared++;
    if (ifA.instr_rdata_o !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL top_word_rdata: got %h want cafef00d", ifA.instr_rdata_o); end
    tick;
    ifA.instr_req_i = 1'b0;
    @(negedge clk);
    compared++;
    if (ifA.instr_err_o !== 1'b1) begin mismatched++; $display("[TB] FAIL high_addr_err: got %b want 1", ifA.instr_err_o); end
    compared++;
    if (ifA.instr_rdata_o !== 32'h0) begin mismatched++; $display("[TB] FAIL high_addr_rdata: got %h want 0", ifA.instr_rdata_o); end
    tick;
    @(negedge clk);
    compared++;
    if ({ifA.instr_rvalid_o, ifA.instr_err_o} !== 2'b00) begin mismatched++; $display("[TB] FAIL err_idle: got %b want 00", {ifA.instr_rvalid_o, ifA.instr_err_o}); end
  endtask

  task automatic test_stall;
    tick;
    ifA.instr_req_i = 1'b1; ifA.instr_addr_i = 32'h8; stallA = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      compared++;
      if (ifA.instr_gnt_o !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_gnt[%0d]: got %b want 0", s, ifA.instr_gnt_o); end
      compared++;
      if (ifA.instr_rvalid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_rvalid[%0d]: got %b want 0", s, ifA.instr_rvalid_o); end
      if (s < 4) tick;
    end
    tick;
    stallA = 1'b0;
    @(negedge clk);
    compared++;
    if (ifA.instr_gnt_o !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_release_gnt: got %b want 1", ifA.instr_gnt_o); end
    tick;
    ifA.instr_req_i = 1'b0;
    @(negedge clk);
    compared++;
    if (ifA.instr_rvalid_o !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_release_rvalid: got %b want 1", ifA.instr_rvalid_o); end
    compared++;
    if (ifA.instr_rdata_o !== 32'h00200113) begin mismatched++; $display("[TB] FAIL stall_release_rdata: got %h want 00200113", ifA.instr_rdata_o); end
  endtask

  task automatic test_load_collision;
    tick;
    ifA.instr_req_i = 1'b1; ifA.instr_addr_i = 32'h8;
    loadWeA = 1'b1; loadAddrA = 10'd2; loadWdataA = 32'hDEADBEEF;
    @(negedge clk);
    compared++;
    if (ifA.instr_gnt_o !== 1'b1) begin mismatched++; $display("[TB] FAIL collide_gnt: got %b want 1", ifA.instr_gnt_o); end
    tick;
    loadWeA = 1'b0;
    @(negedge clk);
    compared++;
    if (ifA.instr_rdata_o !== 32'h00200113) begin mismatched++; $display("[TB] FAIL collide_old_data: got %h want 00200113", ifA.instr_rdata_o); end
    tick;
    ifA.instr_req_i = 1'b0;
    @(negedge clk);
    compared++;
    if (ifA.instr_rdata_o !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL collide_new_data: got %h want deadbeef", ifA.instr_rdata_o); end
    tick;
    @(negedge clk);
    compared++;
    if (gntCntA !== 32'd10) begin mismatched++; $display("[TB] FAIL total_gnt_cnt: got %0d want 10", gntCntA); end
  endtask

  task automatic test_outstanding;
    logic       expGnt;
    logic       expRv;
    logic [1:0] expOut;
    for (int c = 0; c < 9; c++) begin
      tick;
      if (c == 0) begin
        ifB.instr_req_i = 1'b1; ifB.instr_addr_i = 32'h0;
      end
      expGnt = (c % 3) != 2;
      expRv  = (c >= 2) && (((c - 2) % 3) != 2);
      expOut = (c == 0) ? 2'd0 : (((c % 3) == 2) ? 2'd2 : 2'd1);
      @(negedge clk);
      compared++;
      if (ifB.instr_gnt_o !== expGnt) begin mismatched++; $display("[TB] FAIL limit_gnt[%0d]: got %b want %b", c, ifB.instr_gnt_o, expGnt); end
      compared++;
      if (ifB.instr_rvalid_o !== expRv) begin mismatched++; $display("[TB] FAIL limit_rvalid[%0d]: got %b want %b", c, ifB.instr_rvalid_o, expRv); end
      compared++;
      if (outB !== expOut) begin mismatched++; $display("[TB] FAIL limit_outstanding[%0d]: got %0d want %0d", c, outB, expOut); end
      if (expRv) begin
        compared++;
        if (ifB.instr_rdata_o !== 32'h12345678) begin mismatched++; $display("[TB] FAIL limit_rdata[%0d]: got %h want 12345678", c, ifB.instr_rdata_o); end
      end
    end
    tick;
    ifB.instr_req_i = 1'b0;
  endtask

  task automatic test_reset_midflight;
    tick;
    ifC.instr_req_i = 1'b1; ifC.instr_addr_i = 32'h4;
    @(negedge clk);
    compared++;
    if (ifC.instr_gnt_o !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_gnt: got %b want 1", ifC.instr_gnt_o); end
    tick;
    rstC = 1'b1;
    @(negedge clk);
    compared++;
    if (ifC.instr_gnt_o !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_gnt_in_reset: got %b want 0", ifC.instr_gnt_o); end
    tick;
    rstC = 1'b0; ifC.instr_req_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compared++;
      if (ifC.instr_rvalid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_rvalid[%0d]: got %b want 0", c, ifC.instr_rvalid_o); end
      tick;
    end
    @(negedge clk);
    compared++;
    if (outC !== 2'd0) begin mismatched++; $display("[TB] FAIL midrst_outstanding: got %0d want 0", outC); end
    compared++;
    if (gntCntC !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst_gnt_cnt: got %0d want 0", gntCntC); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    prog[0] = 32'h00000013; prog[1] = 32'h00100093;
    prog[2] = 32'h00200113; prog[3] = 32'h00300193;
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    stallA = 1'b0; stallB = 1'b0; stallC = 1'b0;
    loadWeA = 1'b0; loadWeB = 1'b0; loadWeC = 1'b0;
    loadAddrA = '0; loadAddrB = '0; loadAddrC = '0;
    loadWdataA = '0; loadWdataB = '0; loadWdataC = '0;
    ifA.instr_req_i = 1'b0; ifA.instr_addr_i = 32'h0;
    ifB.instr_req_i = 1'b0; ifB.instr_addr_i = 32'h0;
    ifC.instr_req_i = 1'b0; ifC.instr_addr_i = 32'h0;

    test_reset;
    test_back_to_back;
    test_error;
    test_stall;
    test_load_collision;
    test_outstanding;
    test_reset_midflight;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cv32e40p_obi_instr_responder.md
Name: cv32e40p_obi_instr_responder

Overview:
OBI instruction-side responder: the memory end of the prefetch buffer's instr_req/gnt/rvalid interface. It grants requests, reads a word-addressed internal instruction memory, and returns in-order responses after a fixed latency. Out-of-range accesses return an error response. Used as the instruction memory model in fault-tolerant core benches and as a simple boot ROM/RAM in small integrations.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the backing array (power of two, >=4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*MEM_WORDS)
LATENCY, 1, cycles from grant to rvalid (1..4)
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (1..LATENCY+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
instr_req_i  in  1  OBI request
instr_addr_i  in  32  OBI byte address
instr_gnt_o  out  1  OBI grant (combinational)
instr_rvalid_o  out  1  response valid, one cycle per transaction
instr_rdata_o  out  32  response data
instr_err_o  out  1  response error, qualified by rvalid
stall_i  in  1  external grant inhibit
load_we_i  in  1  backdoor write enable
load_addr_i  in  $clog2(MEM_WORDS)  backdoor word index
load_wdata_i  in  32  backdoor write data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count
gnt_cnt_o  out  32  granted-transaction counter

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, outstanding_o=0, gnt_cnt_o=0. Memory contents are not reset.
- instr_gnt_o = instr_req_i & ~stall_i & ~rst & (outstanding < MAX_OUTSTANDING) & ~lfsr_stall (see Optional Feature). The grant does not depend on the previous cycle's grant. A request may be held across stalled cycles with a stable address.
- Acceptance: a transaction is accepted on a cycle where instr_req_i & instr_gnt_o. Address bits [1:0] are ignored. The word index is (addr-BASE_ADDR)>>2.
- Range check at acceptance: in range if BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS. The comparison is unsigned and 33-bit safe, so there is no wrap at 32'hFFFF_FFFF.
- Response pipeline: LATENCY stages, each holding {valid, data, err}. The memory is read in the acceptance cycle; the result enters stage 0 and shifts one stage per cycle.
- instr_rvalid_o is asserted exactly LATENCY cycles after the acceptance edge. Responses are in order, one per accepted request. There is no back-pressure (OBI has no rready).
- Error response: rvalid=1, err=1, rdata=32'h0. Normal response: err=0, rdata=mem[idx].
- When rvalid=0, rdata and err hold 0.
- outstanding: +1 on accept, -1 on rvalid, unchanged when both occur in the same cycle. It never exceeds MAX_OUTSTANDING; reaching it drops grant until a response retires. Accept and retire in the same cycle at the limit: grant stays low that cycle, because the limit check uses the registered count.
- gnt_cnt_o: +1 per accept, wraps 2^32-1 -> 0.
- Backdoor load: mem[load_addr_i] <= load_wdata_i on the edge where load_we_i=1. A read accepted in the same cycle to the same word returns the old data (read-before-write). Load is allowed during reset.
- Reset mid-operation: all in-flight responses are discarded and no rvalid is produced for them. Requests present while rst=1 are not granted.
- stall_i only blocks new grants; in-flight responses still complete on schedule.

Optional Feature:
Macro CV32E40P_OBI_RESP_RANDOM_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with 16'hACE1 on reset and advances every cycle. lfsr_stall = (lfsr[1:0]==2'b00), which inhibits grant on roughly 25% of cycles. This exercises initiator request-hold behaviour.
- Undefined: lfsr_stall=0 and the LFSR is not instantiated.
- All other behaviour is identical in both builds.

Test Plan:
- Preload mem[0..3]={32'h00000013,32'h00100093,32'h00200113,32'h00300193}, LATENCY=1. Four back-to-back requests at 0x0,0x4,0x8,0xC -> gnt every cycle; rvalid on the next 4 cycles with data in order; gnt_cnt_o=4.
- Request addr 32'h0000_1000 (MEM_WORDS=1024) -> gnt=1; one cycle later rvalid=1, err=1, rdata=0. Addr 32'h0000_0FFE -> err=0, returns mem[1023].
- LATENCY=2, MAX_OUTSTANDING=2, req held high -> gnt high 2 cycles, low 1 cycle, then repeats; outstanding_o never exceeds 2; rvalid exactly 2 cycles after each grant.
- stall_i=1 for 5 cycles with req=1, addr=0x8 -> no gnt and no rvalid; on release, gnt in that cycle and rdata=32'h00200113 one cycle later.
- Grant 0x4 at LATENCY=3, assert rst on the next cycle -> no rvalid ever appears; outstanding_o=0 and gnt_cnt_o=0 after reset.
- Same cycle: load_we_i=1, load_addr_i=2, data 32'hDEADBEEF, plus a grant of addr 0x8 -> returns old 32'h00200113; a second read of 0x8 returns 32'hDEADBEEF.
